// File: rtl/instr_loader.sv
// Instruction-memory writer: assembles a big-endian byte stream into words and
// writes them from address 0. Optional checksum stage enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        finish,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [8*BYTES_PER_WORD-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]         word_count,
    output logic                        load_done,
    output logic                        load_err,
    output logic [2:0]                  dbg_state_o
);

    localparam int WORD_WIDTH = 8 * BYTES_PER_WORD;
    localparam int CNT_W      = $clog2(BYTES_PER_WORD) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSEMBLE = 3'd1,
        WRITE    = 3'd2,
        DONE     = 3'd3
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        CHECK    = 3'd4
`endif
    } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // rx_ready never depends on rx_valid, and a start in the same cycle drops the byte.

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic [ADDR_WIDTH:0]     wcount_q, wcount_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic                    we_q, we_d;
    logic                    accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]              xor_q, xor_d;
    logic                    err_q, err_d;
`endif

    assign accept = rx_valid && ready_q && !start;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        wcount_d = wcount_q;
        done_d   = done_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
        err_d    = err_q;
`endif
        if (start) begin
            state_d  = ASSEMBLE;
            addr_d   = '0;
            cnt_d    = '0;
            shift_d  = '0;
            wcount_d = '0;
            done_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_d    = '0;
            err_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ASSEMBLE: begin
                    if (accept) begin
                        shift_d = (shift_q << 8) | WORD_WIDTH'(rx_data);
                        cnt_d   = cnt_q + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        xor_d   = xor_q ^ rx_data;
`endif
                    end
                    // finish discards any partial word, even one completed this cycle
                    if (finish) begin
                        state_d = END_STATE;
                        cnt_d   = '0;
                    end else if (accept && cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    cnt_d    = '0;
                    wcount_d = wcount_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = END_STATE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ASSEMBLE;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        state_d = DONE;
                        done_d  = (rx_data == xor_q);
                        err_d   = (rx_data != xor_q);
                    end
                end
`endif
                default: ;
            endcase
`ifndef INSTR_LOADER_CHECKSUM_EN
            if (state_d == DONE) done_d = 1'b1;
`endif
        end
        ready_d = (state_d == ASSEMBLE)
`ifdef INSTR_LOADER_CHECKSUM_EN
                  || (state_d == CHECK)
`endif
                  ;
        we_d = (state_d == WRITE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            wcount_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            wcount_q <= wcount_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
            err_q    <= err_d;
`endif
        end
    end

    assign rx_ready    = ready_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = shift_q;
    assign word_count  = wcount_q;
    assign load_done   = done_q;
    assign dbg_state_o = state_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign load_err    = err_q;
`else
    assign load_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; covers the checksum stage
// when built with INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

    localparam logic [2:0] S_IDLE = 3'd0, S_ASM = 3'd1, S_WRITE = 3'd2, S_DONE = 3'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, finish = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, mem_we, load_done, load_err;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [5:0]  word_count;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [32];
    logic [4:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [4:0]  exp_addr_q [$];
    logic [15:0] exp_q [$];

    instr_loader dut (
        .CLK(CLK), .RST(RST), .start(start), .finish(finish),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .load_done(load_done), .load_err(load_err),
        .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Instruction memory stand-in plus write log
    always @(posedge CLK) begin
        if (mem_we === 1'b1) begin
            mem_model[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; cycle(); finish = 1'b0;
    endtask

    // Returns #1 after the edge on which the byte was accepted
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (rx_ready === 1'b1) got = 1'b1;
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
        check("send_handshake", 32'(got), 32'd1);
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [15:0] d);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, wr_data_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
            check({tag, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
            check({tag, "_data"}, 32'(wr_data_q.pop_front()), 32'(exp_q.pop_front()));
        end
        wr_addr_q.delete(); wr_data_q.delete(); exp_addr_q.delete(); exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_word_count"}, 32'(word_count), 0);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_load_err"}, 32'(load_err), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = 16'h0000;

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        cycle();
        check("idle_rx_ready", 32'(rx_ready), 0);

        // Single word: latency and registered strobe
        pulse_start();
        check("t1_rx_ready", 32'(rx_ready), 1);
        send_byte(8'h12);
        check("t1_no_early_we", 32'(mem_we), 0);
        send_byte(8'h34);
        check("t1_we", 32'(mem_we), 1);
        check("t1_addr", 32'(mem_addr), 0);
        check("t1_wdata", 32'(mem_wdata), 32'h1234);
        check("t1_rx_ready_low", 32'(rx_ready), 0);
        cycle();
        check("t1_we_one_cycle", 32'(mem_we), 0);
        check("t1_word_count", 32'(word_count), 1);
        pulse_finish();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h26);
`endif
        check("t1_load_done", 32'(load_done), 1);
        expect_write(5'd0, 16'h1234);
        check_writes("t1");

        // Full memory: 32 words, no wrap
        pulse_start();
        check("t2_done_cleared", 32'(load_done), 0);
        check("t2_count_cleared", 32'(word_count), 0);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            send_byte(~8'(i));
            expect_write(5'(i), {8'(i), ~8'(i)});
        end
        check("t2_last_we", 32'(mem_we), 1);
        check("t2_last_addr", 32'(mem_addr), 31);
        check("t2_done_not_yet", 32'(load_done), 0);
        cycle();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("t2_load_done", 32'(load_done), 1);
        check("t2_word_count", 32'(word_count), 32);
        check("t2_we_low", 32'(mem_we), 0);
        check("t2_state", 32'(dbg_state), 32'(S_DONE));
        rx_data = 8'h5A; rx_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("t2_rx_ready_stays_low", 32'(rx_ready), 0);
            @(posedge CLK); #1;
        end
        rx_valid = 1'b0;
        check("t2_addr_no_wrap", 32'(mem_addr), 31);
        check_writes("t2");

        // Early finish with a partial word
        pulse_start();
        send_byte(8'hA0); send_byte(8'hA1);
        send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA4); send_byte(8'hA5);
        send_byte(8'hAA);
        pulse_finish();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'hAB);
`endif
        cycle();
        check("t3_word_count", 32'(word_count), 3);
        check("t3_load_done", 32'(load_done), 1);
        check("t3_mem3_untouched", 32'(mem_model[3]), 32'h03FC);
        expect_write(5'd0, 16'hA0A1);
        expect_write(5'd1, 16'hA2A3);
        expect_write(5'd2, 16'hA4A5);
        check_writes("t3");

        // Restart from DONE, then asynchronous reset mid-load
        pulse_start();
        check("t4_done_drops", 32'(load_done), 0);
        send_byte(8'h55);
        send_byte(8'h66);
        cycle();
        check("t4_word_count", 32'(word_count), 1);
        #3 RST = 1'b1;
        #1;
        check_all_zero("t4_async_reset");
        check("t4_mem_persist", 32'(mem_model[0]), 32'h5566);
        @(posedge CLK); #1;
        RST = 1'b0;
        expect_write(5'd0, 16'h5566);
        check_writes("t4");

        // start and finish together: start wins
        pulse_start();
        send_byte(8'hA1); send_byte(8'hB2);
        send_byte(8'hC3); send_byte(8'hD4);
        cycle();
        check("t5_count_before", 32'(word_count), 2);
        start = 1'b1; finish = 1'b1;
        cycle();
        start = 1'b0; finish = 1'b0;
        check("t5_addr", 32'(mem_addr), 0);
        check("t5_word_count", 32'(word_count), 0);
        check("t5_load_done", 32'(load_done), 0);
        check("t5_rx_ready", 32'(rx_ready), 1);
        check("t5_state", 32'(dbg_state), 32'(S_ASM));

        // start together with a byte handshake: byte dropped
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        cycle();
        start = 1'b0; rx_valid = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        check("t5_we", 32'(mem_we), 1);
        check("t5_wdata", 32'(mem_wdata), 32'h1122);
        check("t5_waddr", 32'(mem_addr), 0);
        cycle();
        expect_write(5'd0, 16'hA1B2);
        expect_write(5'd1, 16'hC3D4);
        expect_write(5'd0, 16'h1122);
        check_writes("t5");

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_byte(8'h12); send_byte(8'h34);
        cycle();
        pulse_finish();
        check("cs_wait_state", 32'(dbg_state), 32'd4);
        send_byte(8'h26);
        check("cs_ok_done", 32'(load_done), 1);
        check("cs_ok_err", 32'(load_err), 0);
        pulse_start();
        send_byte(8'h12); send_byte(8'h34);
        cycle();
        pulse_finish();
        send_byte(8'h27);
        check("cs_bad_done", 32'(load_done), 0);
        check("cs_bad_err", 32'(load_err), 1);
        check("cs_bad_state", 32'(dbg_state), 32'(S_DONE));
        expect_write(5'd0, 16'h1234);
        expect_write(5'd0, 16'h1234);
        check_writes("cs");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
